// File: rtl/bitserial_pkg.sv
// Shared types and constants for the bit-serial adder slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: FSM state encoding, default operand width.
package bitserial_pkg;

  localparam int BS_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/bitserial_adder_if.sv
// Start/busy/done handshake bundle between operand select and the serial adder.
// Latency: none (wiring only).
// Backpressure: none; start is only honoured while the adder is idle or done.
// master: drives start/a/b/cin, observes busy/done/sum/cout. slave: the adder.
interface bitserial_adder_if
  import bitserial_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/bitserial_adder_fa_cell.sv
// Single-bit combinational full adder used as the serial adder's arithmetic cell.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: a, b, ci in; s (sum bit), co (carry out) out.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bitserial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a registered carry.
// Latency: result and done one cycle after the WIDTH-th busy cycle; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy (not queued); accepted in IDLE or DONE.
// Ports: clk, rst_n (async active-low), bus (slave side of bitserial_adder_if).
module bitserial_adder
  import bitserial_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  bitserial_adder_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;

  // psum[0] is always the bit pushed out on the final shift; it is never part of a result.
  logic             unused_psum_lsb;
  assign unused_psum_lsb = psum[0];

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last     = (cnt == CW'(WIDTH - 1));
  // Sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at index 0.
  assign psum_nxt = {fa_s, psum[WIDTH-1:1]};

  fa_cell u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? SHIFT : IDLE;
      SHIFT:   state_nxt = last ? DONE : SHIFT;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry, counter, partial sum, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      psum   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      opa   <= bus.a;
      opb   <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
      psum  <= '0;
    end else if (state == SHIFT) begin
      opa   <= {1'b0, opa[WIDTH-1:1]};
      opb   <= {1'b0, opb[WIDTH-1:1]};
      carry <= fa_co;
      psum  <= psum_nxt;
      if (last) begin
        // Result registers update only here, so they never show partial values.
        sum_q  <= psum_nxt;
        cout_q <= fa_co;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bitserial_adder.sv
// Directed and random checks of bitserial_adder at WIDTH=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_bitserial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bitserial_adder_if #(.WIDTH(8)) bus_if ();

  bitserial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction: start for one cycle, optional stray start at SHIFT cycle glitch_k.
  task automatic run_add(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                         input logic [8:0] expv, input int glitch_k, input string tag);
    int nbusy;
    int ndone;
    nbusy = 0;
    ndone = 0;
    @(negedge clk);
    bus_if.a     = ta;
    bus_if.b     = tbv;
    bus_if.cin   = tc;
    bus_if.start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nbusy += int'(bus_if.busy);
      ndone += int'(bus_if.done);
      if (k == glitch_k) begin
        bus_if.a     = 8'hFF;
        bus_if.b     = 8'hFF;
        bus_if.start = 1'b1;
      end else begin
        bus_if.start = 1'b0;
      end
    end
    @(negedge clk);
    bus_if.start = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    chk({tag, "_early_done"}, 32'(ndone), 32'd0);
    chk({tag, "_done"}, {31'd0, bus_if.done}, 32'd1);
    chk({tag, "_result"}, {23'd0, bus_if.cout, bus_if.sum}, {23'd0, expv});
    @(negedge clk);
    chk({tag, "_done_fall"}, {30'd0, bus_if.busy, bus_if.done}, 32'd0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         ndone;
    total = 0;
    bad   = 0;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    bus_if.cin   = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", {22'd0, bus_if.busy, bus_if.done, bus_if.cout, bus_if.sum}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic add and carry chain.
    run_add(8'h5A, 8'h3C, 1'b0, 9'h096, -1, "basic");
    run_add(8'hFF, 8'h01, 1'b0, 9'h100, -1, "carry_ff_01");
    run_add(8'hFF, 8'h00, 1'b1, 9'h100, -1, "carry_ff_cin");
    run_add(8'h00, 8'h00, 1'b1, 9'h001, -1, "carry_cin_only");

    // Stray start during SHIFT is ignored and not queued.
    run_add(8'h10, 8'h20, 1'b0, 9'h030, 3, "ignored_start");
    repeat (3) @(negedge clk);
    chk("ignored_no_requeue", {30'd0, bus_if.busy, bus_if.done}, 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus_if.a     = 8'h80;
    bus_if.b     = 8'h80;
    bus_if.cin   = 1'b0;
    bus_if.start = 1'b1;
    repeat (9) @(negedge clk);
    chk("b2b_first_done", {31'd0, bus_if.done}, 32'd1);
    chk("b2b_first_result", {23'd0, bus_if.cout, bus_if.sum}, 32'h100);
    bus_if.a = 8'h01;
    bus_if.b = 8'h02;
    @(negedge clk);
    bus_if.start = 1'b0;
    chk("b2b_done_single", {31'd0, bus_if.done}, 32'd0);
    chk("b2b_busy_rise", {31'd0, bus_if.busy}, 32'd1);
    chk("b2b_first_held", {23'd0, bus_if.cout, bus_if.sum}, 32'h100);
    repeat (8) @(negedge clk);
    chk("b2b_second_done", {31'd0, bus_if.done}, 32'd1);
    chk("b2b_second_result", {23'd0, bus_if.cout, bus_if.sum}, 32'h003);
    @(negedge clk);
    chk("b2b_second_fall", {31'd0, bus_if.done}, 32'd0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    bus_if.a     = 8'h11;
    bus_if.b     = 8'h22;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", {31'd0, bus_if.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {22'd0, bus_if.busy, bus_if.done, bus_if.cout, bus_if.sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ndone += int'(bus_if.done) + int'(bus_if.busy);
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    run_add(8'h0F, 8'hF0, 1'b0, 9'h0FF, -1, "after_rst");

    // Random operands against a+b+cin.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(255));
      rb = 8'($urandom_range(255));
      rc = 1'($urandom_range(1));
      run_add(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, -1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
